// File: rtl/sdio_pkg.sv
// Shared definitions for the SD CMD-line receiver.
// Holds the receiver state encoding, frame geometry, the CRC7 generator
// polynomial and the fixed transmission-bit value expected from the host.
package sdio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         FRAME_LEN = 48;
    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam logic       TX_BIT    = 1'b1;

    // Bit counter is loaded with the number of bits still to come after the
    // start bit; the CRC covers every bit down to counter value 9.
    localparam logic [5:0] BIT_CNT_START = 6'(FRAME_LEN - 1);
    localparam logic [5:0] CRC_LAST_CNT  = 6'd9;

endpackage

// File: rtl/sdio_cmd_rx_if.sv
// Decoded-frame bus from the SD CMD receiver to its consumer.
//   cmd_dat_o  {2'b00, command index} of the last valid frame
//   arg_o      32-bit argument of the last valid frame
//   finsh_o    active-low one-cycle frame-done strobe, idles high
//   frm_err_o  one-cycle pulse per discarded frame
//   err_cnt_o  saturating count of discarded frames
interface sdio_cmd_rx_if #(
    parameter int ERRCNT_W = 8
);
    logic [7:0]          cmd_dat_o;
    logic [31:0]         arg_o;
    logic                finsh_o;
    logic                frm_err_o;
    logic [ERRCNT_W-1:0] err_cnt_o;

    modport master (
        output cmd_dat_o,
        output arg_o,
        output finsh_o,
        output frm_err_o,
        output err_cnt_o
    );

    modport slave (
        input cmd_dat_o,
        input arg_o,
        input finsh_o,
        input frm_err_o,
        input err_cnt_o
    );
endinterface

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), MSB first, initial value zero.
//   clk, rst  system clock, async active-low reset
//   clr       synchronous clear to zero (takes priority over en)
//   en        advance the CRC by one bit
//   din       serial data bit
//   crc       current remainder
module crc7_serial
    import sdio_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic fb;

    assign fb = din ^ crc[6];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sdio_cmd_rx.sv
// SD CMD-line frame receiver. Oversamples sd_clk/sd_cmd in the clk domain,
// shifts in 48-bit command frames, validates them and publishes the decoded
// command index and argument.
//   clk, rst       system clock, async active-low reset
//   sd_clk, sd_cmd SD host clock and CMD line, asynchronous, sampled as data
//   bus            decoded-frame outputs (see sdio_cmd_rx_if)
//
// state | meaning
// IDLE  | waiting for a start bit (CMD low on an sd_clk rising edge)
// SHIFT | collecting the 47 bits after the start bit
// CHECK | one cycle: validate transmission bit, end bit and CRC7
// DONE  | one cycle: finsh_o low, outputs just updated
module sdio_cmd_rx
    import sdio_pkg::*;
#(
    parameter int CHECK_CRC = 1,
    parameter int ERRCNT_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sd_clk,
    input  logic          sd_cmd,
    sdio_cmd_rx_if.master bus
);

    logic [1:0]  sd_clk_sync;
    logic [1:0]  sd_cmd_sync;
    logic        sd_clk_prev;
    logic        sd_edge;
    logic        sd_bit;

    state_t      state;
    logic [5:0]  bit_cnt;
    logic [46:0] shreg;
    logic        crc_clr;
    logic        crc_en;
    logic [6:0]  crc;
    logic        frame_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sd_clk_sync <= '0;
            sd_cmd_sync <= '0;
            sd_clk_prev <= 1'b0;
        end else begin
            sd_clk_sync <= {sd_clk_sync[0], sd_clk};
            sd_cmd_sync <= {sd_cmd_sync[0], sd_cmd};
            sd_clk_prev <= sd_clk_sync[1];
        end
    end

    assign sd_edge = sd_clk_sync[1] & ~sd_clk_prev;
    assign sd_bit  = sd_cmd_sync[1];

    // The start bit is always 0, so clearing the CRC is the same as feeding it.
    assign crc_clr = (state == IDLE) && sd_edge && !sd_bit;
    assign crc_en  = (state == SHIFT) && sd_edge && (bit_cnt >= CRC_LAST_CNT);

    crc7_serial u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (sd_bit),
        .crc (crc)
    );

    // shreg layout after the end bit: [46] transmission bit, [45:40] index,
    // [39:8] argument, [7:1] CRC7, [0] end bit.
    assign frame_ok = (shreg[46] == TX_BIT) && shreg[0] &&
                      ((CHECK_CRC == 0) || (shreg[7:1] == crc));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            bus.cmd_dat_o <= '0;
            bus.arg_o     <= '0;
            bus.finsh_o   <= 1'b1;
            bus.frm_err_o <= 1'b0;
            bus.err_cnt_o <= '0;
        end else begin
            bus.frm_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (sd_edge && !sd_bit) begin
                        bit_cnt <= BIT_CNT_START;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sd_edge) begin
                        shreg   <= {shreg[45:0], sd_bit};
                        bit_cnt <= bit_cnt - 6'd1;
                        if (bit_cnt == 6'd1) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (frame_ok) begin
                        bus.cmd_dat_o <= {2'b00, shreg[45:40]};
                        bus.arg_o     <= shreg[39:8];
                        bus.finsh_o   <= 1'b0;
                        state         <= DONE;
                    end else begin
                        bus.frm_err_o <= 1'b1;
                        if (bus.err_cnt_o != '1) begin
                            bus.err_cnt_o <= bus.err_cnt_o + ERRCNT_W'(1);
                        end
                        state <= IDLE;
                    end
                end
                DONE: begin
                    bus.finsh_o <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sdio_cmd_rx.md
SDIO_CMD_RX -- requirements
Module: sdio_cmd_rx

Interface
REQ-001 SHALL have parameter CHECK_CRC, default 1; 1 = frames failing CRC7 are discarded, 0 = CRC7 is still computed but ignored.
REQ-002 SHALL have parameter ERRCNT_W, default 8; width of the saturating error counter.
REQ-003 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sd_clk  input  1  SD host clock, asynchronous to clk, sampled as data.
REQ-006 SHALL have port sd_cmd  input  1  SD CMD line, asynchronous to clk.
REQ-007 SHALL have port cmd_dat_o  output  8  {2'b00, 6-bit command index} of the last valid frame.
REQ-008 SHALL have port arg_o  output  32  argument of the last valid frame, MSB first on the line.
REQ-009 SHALL have port finsh_o  output  1  frame-done strobe, idles high, low for exactly one clk cycle per valid frame.
REQ-010 SHALL have port frm_err_o  output  1  one-cycle high pulse per discarded frame.
REQ-011 SHALL have port err_cnt_o  output  ERRCNT_W  saturating count of discarded frames.

Function
REQ-012 SHALL pass sd_clk and sd_cmd through 2-flop synchronisers and detect an sd_clk rising edge as synced=1, previous=0.
REQ-013 SHALL perform all line sampling only on a detected sd_clk rising edge, using the synchronised sd_cmd value.
REQ-014 SHALL require clk >= 4x sd_clk; behaviour below that ratio is undefined.
REQ-015 SHALL use FSM states IDLE, SHIFT, CHECK, DONE; reset state IDLE.
REQ-016 IDLE: an edge with sd_cmd=0 (start bit) SHALL load bit counter = 47, clear the CRC, and go to SHIFT.
REQ-017 SHALL ignore, in IDLE, any edge with sd_cmd=1.
REQ-018 SHIFT: on each edge, SHALL shift the bit into a 47-bit register and decrement the counter.
REQ-019 SHALL feed the CRC7 with the 39 bits after the start bit; together with the start bit, the CRC covers 40 bits.
REQ-020 SHALL go from SHIFT to CHECK on the clk cycle after the edge that receives the counter=1 bit, i.e. the end bit.
REQ-021 CHECK, one clk cycle: the frame SHALL be valid only if the transmission bit = 1, the end bit = 1, and (CHECK_CRC=0 or received CRC7 == computed CRC7).
REQ-022 For a valid frame, CHECK SHALL go to DONE.
REQ-023 For an invalid frame, CHECK SHALL pulse frm_err_o and go to IDLE.
REQ-024 DONE, one clk cycle: SHALL drive finsh_o=0, then return to IDLE.
REQ-025 SHALL update cmd_dat_o and arg_o in the same cycle finsh_o goes low.
REQ-026 SHALL hold cmd_dat_o and arg_o stable until the next valid frame; invalid frames SHALL NOT alter them.
REQ-027 SHALL compute CRC7 with polynomial x^7+x^3+1, initialised to 0, processed MSB first.
REQ-028 SHALL increment err_cnt_o on every frm_err_o pulse and hold it at all-ones (saturate, no wrap).
REQ-029 Back-to-back frames: a start bit on the first sd_clk edge after returning to IDLE SHALL be accepted.
REQ-030 SHALL ignore any sd_clk edge arriving in CHECK or DONE (guaranteed absent by REQ-014).

Reset
REQ-031 On rst=0, SHALL asynchronously set: state=IDLE, finsh_o=1, frm_err_o=0, cmd_dat_o=0, arg_o=0, err_cnt_o=0, counter=0, CRC=0, synchronisers=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame without any finsh_o or frm_err_o pulse.
REQ-033 After reset release, SHALL treat the first detected sd_clk edge as IDLE sampling.

Structure
REQ-034 SHALL place state encodings, FRAME_LEN=48, CRC7_POLY=7'h09 and the transmission-bit constant in shared package sdio_pkg.
REQ-035 SHALL instantiate one sub-module, crc7_serial: ports clk, rst, clr, en, din, crc[6:0].

Verification
REQ-036 CMD0 frame 40 00 00 00 00 95 -> cmd_dat_o=8'h00, arg_o=0, one finsh_o low cycle, frm_err_o=0.
REQ-037 CMD8 frame 48 00 00 01 AA 87 -> cmd_dat_o=8'h08, arg_o=32'h000001AA, one finsh_o pulse.
REQ-038 CMD17 frame 51 00 00 00 00 55 with one arg bit flipped -> frm_err_o pulse, err_cnt_o=1, outputs keep previous values.
REQ-039 Same flipped frame with CHECK_CRC=0 -> accepted: finsh_o pulse, arg_o equals the flipped value.
REQ-040 rst pulse after 20 bits of CMD8 -> no strobes; a following CMD0 frame is decoded correctly.
REQ-041 Two CMD0 frames separated by zero idle bits -> two finsh_o pulses; a frame with transmission bit 0 -> frm_err_o pulse.
